// File: rtl/ins_memory_banked.sv
// Banked, run-time loadable instruction store; fetch latency 1 cycle (registered ins_val).
// Load port stalls on load_valid=0, deasserts load_ready outside LOAD; fetch is refused while its bank loads.
module ins_memory_banked #(
  parameter int                   WORD_SIZE  = 8,
  parameter int                   INDEX_SIZE = 4,
  parameter int                   BANK_BITS  = 2,
  parameter logic [WORD_SIZE-1:0] FILL_WORD  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_SIZE-1:0] prog_count,
  input  logic                  rd_en,
  output logic [WORD_SIZE-1:0]  ins_val,
  output logic                  ins_valid,
  input  logic [BANK_BITS-1:0]  bank_sel,
  input  logic                  bank_sel_we,
  output logic [BANK_BITS-1:0]  active_bank,
  input  logic                  load_start,
  input  logic [BANK_BITS-1:0]  load_bank,
  input  logic [WORD_SIZE-1:0]  load_data,
  input  logic                  load_valid,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  load_done
);

  localparam int NUM_INS   = 2 ** INDEX_SIZE;
  localparam int NUM_BANKS = 2 ** BANK_BITS;
  localparam logic [INDEX_SIZE-1:0] LAST_PTR = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [INDEX_SIZE-1:0]   wr_ptr_q, wr_ptr_d;
  logic [BANK_BITS-1:0]    tgt_bank_q, tgt_bank_d;
  logic [BANK_BITS-1:0]    active_bank_q;
  logic [WORD_SIZE-1:0]    ins_val_q;
  logic                    ins_valid_q;

  logic                    mem_we;
  logic [WORD_SIZE-1:0]    mem_wdata;
  logic                    fetch_conflict;

  // Not reset: program contents survive a reset, including a partially loaded bank.
  logic [WORD_SIZE-1:0]    mem_q [NUM_BANKS][NUM_INS];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    tgt_bank_d = tgt_bank_q;
    mem_we     = 1'b0;
    mem_wdata  = load_data;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d    = LOAD;
          tgt_bank_d = load_bank;
          wr_ptr_d   = '0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          mem_we = 1'b1;
          if (wr_ptr_q == LAST_PTR) begin
            state_d = DONE;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (load_last) state_d = FILL;
          end
        end
      end
      FILL: begin
        mem_we    = 1'b1;
        mem_wdata = FILL_WORD;
        if (wr_ptr_q == LAST_PTR) state_d = DONE;
        else                      wr_ptr_d = wr_ptr_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      tgt_bank_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      tgt_bank_q <= tgt_bank_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[tgt_bank_q][wr_ptr_q] <= mem_wdata;
  end

  // The bank being rewritten cannot be fetched, so read/write of one address never collides.
  assign fetch_conflict = ((state_q == LOAD) || (state_q == FILL)) &&
                          (tgt_bank_q == active_bank_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_val_q     <= '0;
      ins_valid_q   <= 1'b0;
      active_bank_q <= '0;
    end else begin
      if (rd_en && !fetch_conflict) begin
        ins_val_q   <= mem_q[active_bank_q][prog_count];
        ins_valid_q <= 1'b1;
      end else begin
        ins_valid_q <= 1'b0;
      end
      if (bank_sel_we) active_bank_q <= bank_sel;
    end
  end

  assign ins_val     = ins_val_q;
  assign ins_valid   = ins_valid_q;
  assign active_bank = active_bank_q;
  assign load_ready  = (state_q == LOAD);
  assign load_busy   = (state_q == LOAD) || (state_q == FILL);
  assign load_done   = (state_q == DONE);

endmodule

// File: tb/tb_ins_memory_banked.sv
// Directed bench for ins_memory_banked: fetch vector table plus hand-written load/stall/reset sequences.
module tb_ins_memory_banked;

  logic       clk;
  logic       rst_n;
  logic [3:0] prog_count;
  logic       rd_en;
  logic [7:0] ins_val;
  logic       ins_valid;
  logic [1:0] bank_sel;
  logic       bank_sel_we;
  logic [1:0] active_bank;
  logic       load_start;
  logic [1:0] load_bank;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_last;
  logic       load_ready;
  logic       load_busy;
  logic       load_done;

  int tests;
  int fails;
  logic [7:0] words [16];

  ins_memory_banked dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_count  (prog_count),
    .rd_en       (rd_en),
    .ins_val     (ins_val),
    .ins_valid   (ins_valid),
    .bank_sel    (bank_sel),
    .bank_sel_we (bank_sel_we),
    .active_bank (active_bank),
    .load_start  (load_start),
    .load_bank   (load_bank),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_busy   (load_busy),
    .load_done   (load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic [3:0] pc;
    logic       we;
    logic [1:0] sel;
    logic [7:0] ev;
    logic       evld;
    logic [1:0] eb;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // mode 0: no fetch check, 1: fetch must be refused, 2: fetch must return exp_v
  task automatic fchk(input int mode, input logic [7:0] exp_v);
    if (mode == 1) begin
      chk("conflict_valid", 32'(ins_valid), 0);
    end else if (mode == 2) begin
      chk("other_bank_valid", 32'(ins_valid), 1);
      chk("other_bank_val", 32'(ins_val), 32'(exp_v));
    end
  endtask

  task automatic do_load(input logic [1:0] bank, input int n, input int stall_at,
                         input bit abort, input int mode, input logic [7:0] exp_v);
    int cyc;
    load_start = 1'b1;
    load_bank  = bank;
    tick();
    load_start = 1'b0;
    chk("ld_ready", 32'(load_ready), 1);
    chk("ld_busy", 32'(load_busy), 1);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < 4; s++) begin
          load_valid = 1'b0;
          load_start = 1'b1;
          load_bank  = ~bank;
          load_data  = 8'hEE;
          tick();
          fchk(mode, exp_v);
          chk("stall_ready", 32'(load_ready), 1);
          chk("stall_done", 32'(load_done), 0);
        end
        load_start = 1'b0;
      end
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = (i == n - 1) && !abort;
      tick();
      fchk(mode, exp_v);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    if (!abort) begin
      cyc = 0;
      while (load_done !== 1'b1 && cyc < 40) begin
        chk("fill_ready", 32'(load_ready), 0);
        chk("fill_busy", 32'(load_busy), 1);
        tick();
        fchk(mode, exp_v);
        cyc++;
      end
      chk("fill_cycles", cyc, 16 - n);
      chk("done_pulse", 32'(load_done), 1);
      chk("done_busy", 32'(load_busy), 0);
      tick();
      chk("done_one_cycle", 32'(load_done), 0);
    end
  endtask

  task automatic select(input logic [1:0] b);
    bank_sel    = b;
    bank_sel_we = 1'b1;
    tick();
    bank_sel_we = 1'b0;
    chk("select_bank", 32'(active_bank), 32'(b));
  endtask

  task automatic fetch(input logic [3:0] pc, input logic [7:0] exp_v);
    rd_en      = 1'b1;
    prog_count = pc;
    tick();
    rd_en      = 1'b0;
    chk("fetch_valid", 32'(ins_valid), 1);
    chk("fetch_val", 32'(ins_val), 32'(exp_v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [12];
    tests = 0;
    fails = 0;
    tbl[0]  = '{1'b1, 4'd3,  1'b0, 2'd0, 8'h03, 1'b1, 2'd1};
    tbl[1]  = '{1'b0, 4'd3,  1'b0, 2'd0, 8'h03, 1'b0, 2'd1};
    tbl[2]  = '{1'b1, 4'd4,  1'b1, 2'd2, 8'h04, 1'b1, 2'd2};
    tbl[3]  = '{1'b1, 4'd0,  1'b0, 2'd0, 8'hD5, 1'b1, 2'd2};
    tbl[4]  = '{1'b1, 4'd1,  1'b0, 2'd0, 8'h57, 1'b1, 2'd2};
    tbl[5]  = '{1'b1, 4'd2,  1'b0, 2'd0, 8'hF0, 1'b1, 2'd2};
    tbl[6]  = '{1'b1, 4'd3,  1'b0, 2'd0, 8'h00, 1'b1, 2'd2};
    tbl[7]  = '{1'b1, 4'd15, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2};
    tbl[8]  = '{1'b0, 4'd15, 1'b1, 2'd1, 8'h00, 1'b0, 2'd1};
    tbl[9]  = '{1'b1, 4'd15, 1'b0, 2'd0, 8'h0F, 1'b1, 2'd1};
    tbl[10] = '{1'b1, 4'd9,  1'b1, 2'd2, 8'h09, 1'b1, 2'd2};
    tbl[11] = '{1'b1, 4'd9,  1'b0, 2'd0, 8'h00, 1'b1, 2'd2};

    rst_n = 1'b0; prog_count = '0; rd_en = 1'b0; bank_sel = '0; bank_sel_we = 1'b0;
    load_start = 1'b0; load_bank = '0; load_data = '0; load_valid = 1'b0; load_last = 1'b0;
    tick();
    tick();
    chk("rst_ins_val", 32'(ins_val), 0);
    chk("rst_ins_valid", 32'(ins_valid), 0);
    chk("rst_active_bank", 32'(active_bank), 0);
    chk("rst_load_ready", 32'(load_ready), 0);
    chk("rst_load_busy", 32'(load_busy), 0);
    chk("rst_load_done", 32'(load_done), 0);
    rst_n = 1'b1;
    tick();

    // Full 16-word program, no fill
    for (int i = 0; i < 16; i++) words[i] = 8'(i);
    do_load(2'd1, 16, -1, 1'b0, 0, 8'h00);
    select(2'd1);
    fetch(4'd5, 8'h05);

    // Short program padded by FILL
    words[0] = 8'hD5; words[1] = 8'h57; words[2] = 8'hF0;
    do_load(2'd2, 3, -1, 1'b0, 0, 8'h00);

    for (int i = 0; i < 12; i++) begin
      rd_en       = tbl[i].rd;
      prog_count  = tbl[i].pc;
      bank_sel_we = tbl[i].we;
      bank_sel    = tbl[i].sel;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(ins_valid), 32'(tbl[i].evld));
      chk($sformatf("vec%0d_val", i), 32'(ins_val), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_bank", i), 32'(active_bank), 32'(tbl[i].eb));
    end
    rd_en = 1'b0;
    bank_sel_we = 1'b0;

    // Loading the active bank blocks fetch; loading another bank does not
    select(2'd0);
    rd_en = 1'b1;
    prog_count = 4'd0;
    words[0] = 8'hA1; words[1] = 8'hB2;
    do_load(2'd0, 2, -1, 1'b0, 1, 8'h00);
    chk("post_load_valid", 32'(ins_valid), 1);
    chk("post_load_val", 32'(ins_val), 32'hA1);
    prog_count = 4'd1;
    words[0] = 8'h31; words[1] = 8'h32; words[2] = 8'h33; words[3] = 8'h34;
    do_load(2'd3, 4, -1, 1'b0, 2, 8'hB2);
    rd_en = 1'b0;

    // Stall mid-stream with an ignored load_start aimed at bank 0
    words[0] = 8'hC0; words[1] = 8'hC1; words[2] = 8'hC2;
    do_load(2'd3, 3, 2, 1'b0, 0, 8'h00);
    select(2'd3);
    fetch(4'd0, 8'hC0);
    fetch(4'd1, 8'hC1);
    fetch(4'd2, 8'hC2);
    fetch(4'd3, 8'h00);
    select(2'd0);
    fetch(4'd0, 8'hA1);
    fetch(4'd1, 8'hB2);

    // Reset in the middle of a load
    select(2'd1);
    fetch(4'd7, 8'h07);
    for (int i = 0; i < 7; i++) words[i] = 8'h70 + 8'(i);
    do_load(2'd2, 7, -1, 1'b1, 0, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("midrst_ins_val", 32'(ins_val), 0);
    chk("midrst_valid", 32'(ins_valid), 0);
    chk("midrst_bank", 32'(active_bank), 0);
    chk("midrst_ready", 32'(load_ready), 0);
    chk("midrst_busy", 32'(load_busy), 0);
    chk("midrst_done", 32'(load_done), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_done", 32'(load_done), 0);
      chk("postrst_busy", 32'(load_busy), 0);
      chk("postrst_ready", 32'(load_ready), 0);
    end
    select(2'd2);
    for (int i = 0; i < 7; i++) fetch(4'(i), 8'h70 + 8'(i));
    fetch(4'd7, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
